read_seq_driver: RTL and testbench
==================================

# read_seq_driver

Parametrised read-address sequencer for the register-file read ports in the pipeline. On a start command it walks a programmable block of addresses, presenting NUM_PORTS consecutive addresses per beat on its read-address outputs. Beats advance under a valid/ready handshake, with optional looping and abort. The state is exported for the HEX debug display.

## Interface
- ADDR_W, 5: width of every read address, base and count.
- NUM_PORTS, 2: number of read-address outputs driven per beat (≥1).
- i_CLK  in  1  clock; all logic on rising edge.
- i_RST  in  1  reset; synchronous, active-high.
- i_start  in  1  start command; sampled only in IDLE.
- i_base_addr  in  ADDR_W  first address of the block; latched on start.
- i_count  in  ADDR_W  number of beats; latched on start.
- i_loop  in  1  repeat mode; latched on start.
- i_abort  in  1  terminate the current sequence.
- i_ready  in  1  consumer accepts the current beat.
- o_rdaddr  out  NUM_PORTS*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- o_valid  out  1  o_rdaddr holds a live beat.
- o_busy  out  1  high in ISSUE and DONE.
- o_done  out  1  one-cycle completion pulse.
- o_state_HEX0  out  4  current state code (debug).

## Operation
- States and codes: IDLE=0, ISSUE=1, DONE=2. Unused codes return to IDLE.
- IDLE:
  - i_start=1 and i_count≠0: latch base, count and loop; go to ISSUE.
  - i_start=1 and i_count=0: go to DONE; no beats are issued.
- ISSUE:
  - Beat j drives port p with (base + j*NUM_PORTS + p) mod 2^ADDR_W. Address wrap-around is silent.
  - Implement as a running pointer that advances by NUM_PORTS; no multiplier.
  - A beat is accepted on an edge where o_valid=1 and i_ready=1. Without acceptance, addresses hold.
  - On acceptance of the last beat (j = count-1):
    - Non-loop: go to DONE.
    - Loop: return to beat 0, with the pointer reset to base, in the next cycle with no gap. Loop mode never reaches DONE without abort.
- Abort:
  - In ISSUE, i_abort=1 goes to DONE at that edge. Abort takes priority over acceptance; the beat on that edge is not counted.
  - i_abort is ignored in IDLE and DONE.
- DONE: lasts exactly one cycle with o_done=1, then IDLE.
- i_start is ignored outside IDLE. No queuing.
- Reset mid-operation: state IDLE, all outputs 0. Any sequence in flight is discarded.

## Timing
- Reset values: o_rdaddr=0, o_valid=0, o_busy=0, o_done=0, o_state_HEX0=0.
- All outputs are registered.
- Start latency: start sampled at edge k gives o_valid=1 and beat-0 addresses from edge k (visible in cycle k+1).
- Throughput: with i_ready held at 1, one beat per cycle. Beat j is visible after edge k+j.
- After the last acceptance at edge m: o_valid=0 and o_done=1 after edge m; IDLE after edge m+1.
- A new start is accepted at the earliest at the edge after DONE, i.e. from IDLE.
- o_valid never drops while in ISSUE. Stalling is expressed only through i_ready.
- Beat counter is ADDR_W bits; maximum 2^ADDR_W-1 beats per pass.

## Structure
- Package read_seq_pkg holds:
  - the state type and its 4-bit codes (IDLE, ISSUE, DONE);
  - default ADDR_W and NUM_PORTS constants shared with the register-file wrapper.
- Single module. The per-port offset add is a generate loop, not a sub-module.

## Test plan
- Default parameters; base=0, count=3, ready=1 → beats (0,1), (2,3), (4,5) on consecutive cycles, then o_done pulse, then IDLE. This reproduces the legacy walk.
- base=30, count=2 → beats (30,31), (0,1): wrap-around with no flag.
- base=4, count=3, ready low for 2 cycles during beat 1 → (6,7) held for 3 cycles with o_valid=1; total 5 cycles in ISSUE.
- loop=1, base=8, count=2 → (8,9), (10,11), (8,9), … continuously. i_abort mid-beat → o_valid=0 and o_done=1 the next cycle.
- count=0 start → DONE for one cycle, o_valid never set. i_start during ISSUE → ignored.
- i_RST asserted in ISSUE → all outputs 0 and HEX=0 after the edge. A start on the cycle after reset works normally.
- NUM_PORTS=3, ADDR_W=4, base=14, count=2 → beats (14,15,0), (1,2,3).

Source files
------------

// File: rtl/read_seq_driver_pkg.sv
// Shared types and default sizing for the register-file read-address sequencer.
// The state codes double as the value shown on the debug HEX digit.
package read_seq_pkg;

  localparam int unsigned RS_ADDR_W    = 5;
  localparam int unsigned RS_NUM_PORTS = 2;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ISSUE = 4'd1,
    ST_DONE  = 4'd2
  } rs_state_e;

endpackage

// File: rtl/read_seq_driver_if.sv
// Command, read-address and status bundle between the sequencer and its users.
// The sequencer side is the master; the register-file wrapper side is the slave.
interface read_seq_driver_if #(
  parameter int ADDR_W    = 5,
  parameter int NUM_PORTS = 2
);

  logic                        i_start;
  logic [ADDR_W-1:0]           i_base_addr;
  logic [ADDR_W-1:0]           i_count;
  logic                        i_loop;
  logic                        i_abort;
  logic                        i_ready;
  logic [NUM_PORTS*ADDR_W-1:0] o_rdaddr;
  logic                        o_valid;
  logic                        o_busy;
  logic                        o_done;
  logic [3:0]                  o_state_HEX0;

  modport master (
    input  i_start, i_base_addr, i_count, i_loop, i_abort, i_ready,
    output o_rdaddr, o_valid, o_busy, o_done, o_state_HEX0
  );

  modport slave (
    output i_start, i_base_addr, i_count, i_loop, i_abort, i_ready,
    input  o_rdaddr, o_valid, o_busy, o_done, o_state_HEX0
  );

endinterface

// File: rtl/read_seq_driver.sv
// Walks a block of register-file read addresses, NUM_PORTS consecutive addresses
// per beat, advancing on valid/ready with optional looping and abort.
module read_seq_driver
  import read_seq_pkg::*;
#(
  parameter int ADDR_W    = RS_ADDR_W,
  parameter int NUM_PORTS = RS_NUM_PORTS
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  read_seq_driver_if.master bus
);

  rs_state_e                   state_q, state_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic [ADDR_W-1:0]           count_q, count_d;
  logic                        loop_q, loop_d;
  logic [ADDR_W-1:0]           ptr_q, ptr_d;
  logic [ADDR_W-1:0]           beat_q, beat_d;
  logic [NUM_PORTS*ADDR_W-1:0] rdaddr_q, rdaddr_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        last_beat;

  assign last_beat = (beat_q == count_q - ADDR_W'(1));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    loop_d  = loop_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_count != '0) begin
            base_d  = bus.i_base_addr;
            count_d = bus.i_count;
            loop_d  = bus.i_loop;
            ptr_d   = bus.i_base_addr;
            beat_d  = '0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        // Abort wins over a simultaneous acceptance; that beat is not counted.
        if (bus.i_abort) begin
          state_d = ST_DONE;
        end else if (bus.i_ready) begin
          if (last_beat) begin
            if (loop_q) begin
              ptr_d  = base_q;
              beat_d = '0;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            ptr_d  = ptr_q + ADDR_W'(NUM_PORTS);
            beat_d = beat_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign valid_d = (state_d == ST_ISSUE);
  assign busy_d  = (state_d == ST_ISSUE) || (state_d == ST_DONE);
  assign done_d  = (state_d == ST_DONE);

  // Per-port offsets are added ahead of the output register so o_rdaddr is a flop.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign rdaddr_d[gi*ADDR_W +: ADDR_W] = valid_d ? (ptr_d + ADDR_W'(gi)) : '0;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      loop_q   <= 1'b0;
      ptr_q    <= '0;
      beat_q   <= '0;
      rdaddr_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      loop_q   <= loop_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
      rdaddr_q <= rdaddr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_rdaddr     = rdaddr_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_state_HEX0 = state_q;

endmodule

// File: tb/tb_read_seq_driver.sv
// Directed bench for read_seq_driver: two instances (5-bit/2-port, 4-bit/3-port)
// share one stimulus stream and are each compared against a beat-index model.
module tb_read_seq_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_r;
  logic [4:0] base_r;
  logic [4:0] count_r;
  logic       loop_r;
  logic       abort_r;
  logic       ready_r;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int AW = (gi == 0) ? 5 : 4;
    localparam int NP = (gi == 0) ? 2 : 3;

    read_seq_driver_if #(.ADDR_W(AW), .NUM_PORTS(NP)) bus ();

    assign bus.i_start     = start_r;
    assign bus.i_base_addr = base_r[AW-1:0];
    assign bus.i_count     = count_r[AW-1:0];
    assign bus.i_loop      = loop_r;
    assign bus.i_abort     = abort_r;
    assign bus.i_ready     = ready_r;

    read_seq_driver #(.ADDR_W(AW), .NUM_PORTS(NP)) dut (
      .i_CLK (clk),
      .i_RST (rst),
      .bus   (bus)
    );

    // Model: phase 0 idle, 1 issuing beat m_j, 2 done pulse.
    int m_phase = 0;
    int m_j     = 0;
    int m_base  = 0;
    int m_count = 0;
    bit m_loop  = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        m_phase <= 0;
        m_j     <= 0;
      end else if (m_phase == 0) begin
        if (start_r) begin
          if (count_r[AW-1:0] != 0) begin
            m_base  <= int'(base_r[AW-1:0]);
            m_count <= int'(count_r[AW-1:0]);
            m_loop  <= loop_r;
            m_j     <= 0;
            m_phase <= 1;
          end else begin
            m_phase <= 2;
          end
        end
      end else if (m_phase == 1) begin
        if (abort_r) m_phase <= 2;
        else if (ready_r) begin
          if (m_j == m_count - 1) begin
            if (m_loop) m_j <= 0;
            else m_phase <= 2;
          end else begin
            m_j <= m_j + 1;
          end
        end
      end else begin
        m_phase <= 0;
      end
    end

    always @(negedge clk) begin
      logic [NP*AW-1:0] exp_addr;
      exp_addr = '0;
      for (int p = 0; p < NP; p++)
        exp_addr[p*AW +: AW] = AW'((m_base + m_j * NP + p) % (1 << AW));
      chk($sformatf("i%0d_valid", gi), 32'(bus.o_valid), 32'(m_phase == 1));
      chk($sformatf("i%0d_busy", gi), 32'(bus.o_busy), 32'(m_phase != 0));
      chk($sformatf("i%0d_done", gi), 32'(bus.o_done), 32'(m_phase == 2));
      chk($sformatf("i%0d_hex", gi), 32'(bus.o_state_HEX0), 32'(m_phase));
      if (m_phase == 1)
        chk($sformatf("i%0d_rdaddr_beat%0d", gi, m_j), 32'(bus.o_rdaddr), 32'(exp_addr));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int c, input bit l);
    start_r = 1'b1;
    base_r  = 5'(b);
    count_r = 5'(c);
    loop_r  = l;
    step(1);
    start_r = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_i0_rdaddr"}, 32'(g_inst[0].bus.o_rdaddr), 0);
    chk({nm, "_i0_valid"}, 32'(g_inst[0].bus.o_valid), 0);
    chk({nm, "_i0_busy"}, 32'(g_inst[0].bus.o_busy), 0);
    chk({nm, "_i0_done"}, 32'(g_inst[0].bus.o_done), 0);
    chk({nm, "_i0_hex"}, 32'(g_inst[0].bus.o_state_HEX0), 0);
    chk({nm, "_i1_rdaddr"}, 32'(g_inst[1].bus.o_rdaddr), 0);
    chk({nm, "_i1_hex"}, 32'(g_inst[1].bus.o_state_HEX0), 0);
  endtask

  int vcnt;

  initial begin
    rst = 1'b1; start_r = 1'b0; base_r = '0; count_r = '0;
    loop_r = 1'b0; abort_r = 1'b0; ready_r = 1'b1;
    step(3);
    chk_zero("reset");
    rst = 1'b0;
    step(1);

    // Legacy walk: (0,1) (2,3) (4,5)
    do_start(0, 3, 1'b0);
    chk("walk_b0", 32'(g_inst[0].bus.o_rdaddr), 32);
    chk("walk_b0_hex", 32'(g_inst[0].bus.o_state_HEX0), 1);
    step(1);
    chk("walk_b1", 32'(g_inst[0].bus.o_rdaddr), 98);
    step(1);
    chk("walk_b2", 32'(g_inst[0].bus.o_rdaddr), 164);
    step(1);
    chk("walk_done", 32'(g_inst[0].bus.o_done), 1);
    chk("walk_done_valid", 32'(g_inst[0].bus.o_valid), 0);
    step(1);
    chk("walk_idle_busy", 32'(g_inst[0].bus.o_busy), 0);

    // Wrap-around: (30,31) (0,1); 3-port/4-bit instance sees (14,15,0) (1,2,3)
    do_start(30, 2, 1'b0);
    chk("wrap_b0", 32'(g_inst[0].bus.o_rdaddr), 1022);
    chk("wrap3_b0", 32'(g_inst[1].bus.o_rdaddr), 254);
    step(1);
    chk("wrap_b1", 32'(g_inst[0].bus.o_rdaddr), 32);
    chk("wrap3_b1", 32'(g_inst[1].bus.o_rdaddr), 801);
    step(2);

    // Stall during beat 1: (6,7) held three cycles, five cycles in ISSUE
    vcnt = 0;
    do_start(4, 3, 1'b0);
    if (g_inst[0].bus.o_valid) vcnt++;
    step(1);
    if (g_inst[0].bus.o_valid) vcnt++;
    ready_r = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      if (g_inst[0].bus.o_valid) vcnt++;
    end
    chk("stall_hold", 32'(g_inst[0].bus.o_rdaddr), 230);
    chk("stall_hold_valid", 32'(g_inst[0].bus.o_valid), 1);
    ready_r = 1'b1;
    step(1);
    if (g_inst[0].bus.o_valid) vcnt++;
    chk("stall_b2", 32'(g_inst[0].bus.o_rdaddr), 296);
    step(1);
    if (g_inst[0].bus.o_valid) vcnt++;
    chk("stall_issue_cycles", 32'(vcnt), 5);
    step(1);

    // Loop with an ignored start during ISSUE, then abort
    do_start(8, 2, 1'b1);
    chk("loop_b0", 32'(g_inst[0].bus.o_rdaddr), 296);
    start_r = 1'b1; base_r = 5'd0; count_r = 5'd1; loop_r = 1'b0;
    step(1);
    start_r = 1'b0;
    chk("loop_b1", 32'(g_inst[0].bus.o_rdaddr), 362);
    step(1);
    chk("loop_b0_again", 32'(g_inst[0].bus.o_rdaddr), 296);
    step(2);
    abort_r = 1'b1;
    step(1);
    abort_r = 1'b0;
    chk("abort_done", 32'(g_inst[0].bus.o_done), 1);
    chk("abort_valid", 32'(g_inst[0].bus.o_valid), 0);
    step(1);
    chk("abort_idle_hex", 32'(g_inst[0].bus.o_state_HEX0), 0);

    // Zero-count start
    do_start(5, 0, 1'b0);
    chk("zero_done", 32'(g_inst[0].bus.o_done), 1);
    chk("zero_hex", 32'(g_inst[0].bus.o_state_HEX0), 2);
    chk("zero_valid", 32'(g_inst[0].bus.o_valid), 0);
    step(1);

    // Reset mid-ISSUE, then an immediate start
    do_start(3, 3, 1'b0);
    rst = 1'b1;
    step(1);
    chk_zero("midrst");
    rst = 1'b0;
    do_start(10, 1, 1'b0);
    chk("postrst_b0", 32'(g_inst[0].bus.o_rdaddr), 362);
    chk("postrst3_b0", 32'(g_inst[1].bus.o_rdaddr), 3258);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
